// File: rtl/channel_file.sv
// rtl/channel_file.sv - 16-channel register file with accumulator, bypassed reads and sample snapshot (optional ACC_SATURATE_EN)
module channel_file #(
    parameter int data_width  = 16,
    parameter int out_channel = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    sample_tick,
    input  logic [3:0]              channel_write_addr,
    input  logic [data_width-1:0]   channel_write_val,
    input  logic                    channel_write_enable,
    input  logic [2*data_width-1:0] accumulator_write_val,
    input  logic                    accumulator_write_enable,
    input  logic                    accumulator_add_enable,
    input  logic [3:0]              rd_addr_a,
    input  logic [3:0]              rd_addr_b,
    output logic [data_width-1:0]   rd_val_a,
    output logic [data_width-1:0]   rd_val_b,
    input  logic [4:0]              acc_shift,
    output logic [data_width-1:0]   acc_read_val,
    output logic [2*data_width-1:0] acc_val,
    output logic [data_width-1:0]   sample_out,
    output logic                    sample_out_valid
);

    localparam int AW = 2 * data_width;
    localparam logic [3:0] OUT_IDX = 4'(out_channel);
    localparam logic [data_width-1:0] RD_MAX = {1'b0, {(data_width-1){1'b1}}};
    localparam logic [data_width-1:0] RD_MIN = {1'b1, {(data_width-1){1'b0}}};

    logic [data_width-1:0] ch_q [16];
    logic [data_width-1:0] ch_d [16];
    logic [AW-1:0]         acc_q, acc_d;
    logic [data_width-1:0] rd_a_q, rd_a_d;
    logic [data_width-1:0] rd_b_q, rd_b_d;
    logic [data_width-1:0] acc_rd_q, acc_rd_d;
    logic [data_width-1:0] sample_q, sample_d;
    logic                  sample_vld_q, sample_vld_d;

    logic                  ch_wr;
    logic                  acc_wr;
    logic [AW-1:0]         acc_sum;
    logic signed [AW-1:0]  acc_shifted;
    logic [AW-data_width:0] shifted_top;

`ifdef ACC_SATURATE_EN
    logic [AW:0]           sum_ext;
`endif

    assign ch_wr  = enable && channel_write_enable;
    assign acc_wr = enable && accumulator_write_enable;

    // Accumulate result: sign-extended add clamps on overflow, otherwise wraps
    always_comb begin
`ifdef ACC_SATURATE_EN
        sum_ext = {acc_q[AW-1], acc_q} + {accumulator_write_val[AW-1], accumulator_write_val};
        if (sum_ext[AW] != sum_ext[AW-1]) begin
            acc_sum = sum_ext[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        end else begin
            acc_sum = sum_ext[AW-1:0];
        end
`else
        acc_sum = acc_q + accumulator_write_val;
`endif
    end

    // Next-state for storage, read ports, accumulator read and sample snapshot
    always_comb begin
        ch_d = ch_q;
        if (ch_wr) begin
            ch_d[channel_write_addr] = channel_write_val;
        end

        acc_d = acc_q;
        if (acc_wr) begin
            acc_d = accumulator_add_enable ? acc_sum : accumulator_write_val;
        end

        rd_a_d = (ch_wr && channel_write_addr == rd_addr_a) ? channel_write_val : ch_q[rd_addr_a];
        rd_b_d = (ch_wr && channel_write_addr == rd_addr_b) ? channel_write_val : ch_q[rd_addr_b];

        // Shift of 2*data_width or more fills with sign bits; clamp if the
        // bits above the data_width result are not all copies of its sign.
        acc_shifted = $signed(acc_q) >>> acc_shift;
        shifted_top = acc_shifted[AW-1:data_width-1];
        if ((&shifted_top) || !(|shifted_top)) begin
            acc_rd_d = acc_shifted[data_width-1:0];
        end else begin
            acc_rd_d = acc_shifted[AW-1] ? RD_MIN : RD_MAX;
        end

        sample_d     = sample_tick ? ch_q[OUT_IDX] : sample_q;
        sample_vld_d = sample_tick;
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                ch_q[i] <= '0;
            end
            acc_q        <= '0;
            rd_a_q       <= '0;
            rd_b_q       <= '0;
            acc_rd_q     <= '0;
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                ch_q[i] <= ch_d[i];
            end
            acc_q        <= acc_d;
            rd_a_q       <= rd_a_d;
            rd_b_q       <= rd_b_d;
            acc_rd_q     <= acc_rd_d;
            sample_q     <= sample_d;
            sample_vld_q <= sample_vld_d;
        end
    end

    assign rd_val_a         = rd_a_q;
    assign rd_val_b         = rd_b_q;
    assign acc_read_val     = acc_rd_q;
    assign acc_val          = acc_q;
    assign sample_out       = sample_q;
    assign sample_out_valid = sample_vld_q;

endmodule

// File: tb/tb_channel_file.sv
// tb/tb_channel_file.sv - vector table and scoreboard bench for channel_file
module tb_channel_file;

    localparam int CK_RA  = 1;
    localparam int CK_RB  = 2;
    localparam int CK_ACC = 4;
    localparam int CK_ARD = 8;
    localparam int CK_SMP = 16;
    localparam int CK_SV  = 32;
    localparam int CK_ALL = 63;

`ifdef ACC_SATURATE_EN
    localparam logic [31:0] E_OVF_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] E_OVF_NEG = 32'h8000_0000;
`else
    localparam logic [31:0] E_OVF_POS = 32'h8000_0010;
    localparam logic [31:0] E_OVF_NEG = 32'h7FFF_FFF0;
`endif

    typedef struct {
        string       name;
        logic        en, tick, cwe;
        logic [3:0]  caddr;
        logic [15:0] cval;
        logic        awe, aadd;
        logic [31:0] aval;
        logic [3:0]  ra, rb;
        logic [4:0]  sh;
        int          chk;
        logic [15:0] e_ra, e_rb;
        logic [31:0] e_acc;
        logic [15:0] e_ard, e_smp;
        logic        e_sv;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable, sample_tick;
    logic [3:0]  channel_write_addr;
    logic [15:0] channel_write_val;
    logic        channel_write_enable;
    logic [31:0] accumulator_write_val;
    logic        accumulator_write_enable, accumulator_add_enable;
    logic [3:0]  rd_addr_a, rd_addr_b;
    logic [15:0] rd_val_a, rd_val_b;
    logic [4:0]  acc_shift;
    logic [15:0] acc_read_val;
    logic [31:0] acc_val;
    logic [15:0] sample_out;
    logic        sample_out_valid;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t tbl[$];
    vec_t sb[$];
    logic [15:0] mdl [16];

    always #5 clk = ~clk;

    channel_file dut (
        .clk                      (clk),
        .reset                    (reset),
        .enable                   (enable),
        .sample_tick              (sample_tick),
        .channel_write_addr       (channel_write_addr),
        .channel_write_val        (channel_write_val),
        .channel_write_enable     (channel_write_enable),
        .accumulator_write_val    (accumulator_write_val),
        .accumulator_write_enable (accumulator_write_enable),
        .accumulator_add_enable   (accumulator_add_enable),
        .rd_addr_a                (rd_addr_a),
        .rd_addr_b                (rd_addr_b),
        .rd_val_a                 (rd_val_a),
        .rd_val_b                 (rd_val_b),
        .acc_shift                (acc_shift),
        .acc_read_val             (acc_read_val),
        .acc_val                  (acc_val),
        .sample_out               (sample_out),
        .sample_out_valid         (sample_out_valid)
    );

    function automatic vec_t mk(input string name, input logic en, input logic tick,
                                input logic cwe, input logic [3:0] caddr, input logic [15:0] cval,
                                input logic awe, input logic aadd, input logic [31:0] aval,
                                input logic [3:0] ra, input logic [3:0] rb, input logic [4:0] sh,
                                input int chk, input logic [15:0] e_ra, input logic [15:0] e_rb,
                                input logic [31:0] e_acc, input logic [15:0] e_ard,
                                input logic [15:0] e_smp, input logic e_sv);
        vec_t v;
        v.name = name; v.en = en; v.tick = tick; v.cwe = cwe; v.caddr = caddr; v.cval = cval;
        v.awe = awe; v.aadd = aadd; v.aval = aval; v.ra = ra; v.rb = rb; v.sh = sh;
        v.chk = chk; v.e_ra = e_ra; v.e_rb = e_rb; v.e_acc = e_acc; v.e_ard = e_ard;
        v.e_smp = e_smp; v.e_sv = e_sv;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        enable = 1'b1; sample_tick = 1'b0;
        channel_write_enable = 1'b0; channel_write_addr = '0; channel_write_val = '0;
        accumulator_write_enable = 1'b0; accumulator_add_enable = 1'b0; accumulator_write_val = '0;
        rd_addr_a = '0; rd_addr_b = '0; acc_shift = '0;
    endtask

    // Drive one vector between edges, queue its expectation, compare after the edge
    task automatic run_vec(input vec_t v);
        vec_t e;
        @(negedge clk);
        enable = v.en; sample_tick = v.tick;
        channel_write_enable = v.cwe; channel_write_addr = v.caddr; channel_write_val = v.cval;
        accumulator_write_enable = v.awe; accumulator_add_enable = v.aadd;
        accumulator_write_val = v.aval;
        rd_addr_a = v.ra; rd_addr_b = v.rb; acc_shift = v.sh;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if ((e.chk & CK_RA)  != 0) cmp({e.name, ".rd_val_a"}, 32'(rd_val_a), 32'(e.e_ra));
        if ((e.chk & CK_RB)  != 0) cmp({e.name, ".rd_val_b"}, 32'(rd_val_b), 32'(e.e_rb));
        if ((e.chk & CK_ACC) != 0) cmp({e.name, ".acc_val"}, acc_val, e.e_acc);
        if ((e.chk & CK_ARD) != 0) cmp({e.name, ".acc_read_val"}, 32'(acc_read_val), 32'(e.e_ard));
        if ((e.chk & CK_SMP) != 0) cmp({e.name, ".sample_out"}, 32'(sample_out), 32'(e.e_smp));
        if ((e.chk & CK_SV)  != 0) cmp({e.name, ".sample_out_valid"}, 32'(sample_out_valid), 32'(e.e_sv));
    endtask

    task automatic check_all_zero(input string tag);
        cmp({tag, ".rd_val_a"}, 32'(rd_val_a), 32'h0);
        cmp({tag, ".rd_val_b"}, 32'(rd_val_b), 32'h0);
        cmp({tag, ".acc_val"}, acc_val, 32'h0);
        cmp({tag, ".acc_read_val"}, 32'(acc_read_val), 32'h0);
        cmp({tag, ".sample_out"}, 32'(sample_out), 32'h0);
        cmp({tag, ".sample_out_valid"}, 32'(sample_out_valid), 32'h0);
    endtask

    initial begin
        logic [31:0] acc_exp;
        logic [15:0] wv;
        logic [3:0]  ra_i;
        vec_t v;

        //           name            en tk cw ad  cval      aw ad aval           ra  rb  sh  chk                          e_ra      e_rb      e_acc          e_ard     e_smp     sv
        tbl.push_back(mk("bypass_wr5",   1, 0, 1, 5, 16'h1234, 0, 0, 32'h0,         5,  6,  0, CK_ALL,                      16'h1234, 16'h0000, 32'h0,         16'h0000, 16'h0000, 0));
        tbl.push_back(mk("acc_ovw",      1, 0, 0, 0, 16'h0,    1, 0, 32'h100,       5,  5,  4, CK_ALL,                      16'h1234, 16'h1234, 32'h100,       16'h0000, 16'h0000, 0));
        tbl.push_back(mk("acc_add",      1, 0, 0, 0, 16'h0,    1, 1, 32'h50,        5,  6,  4, CK_ALL,                      16'h1234, 16'h0000, 32'h150,       16'h0010, 16'h0000, 0));
        tbl.push_back(mk("acc_rd_lat",   1, 0, 0, 0, 16'h0,    0, 0, 32'h0,         6,  5,  4, CK_ALL,                      16'h0000, 16'h1234, 32'h150,       16'h0015, 16'h0000, 0));
        tbl.push_back(mk("ovw_pos",      1, 0, 0, 0, 16'h0,    1, 0, 32'h7FFF_FFF0, 5,  5,  0, CK_RA|CK_RB|CK_ACC|CK_ARD,   16'h1234, 16'h1234, 32'h7FFF_FFF0, 16'h0150, 16'h0, 0));
        tbl.push_back(mk("add_ovf_pos",  1, 0, 0, 0, 16'h0,    1, 1, 32'h20,        5,  5,  0, CK_ACC|CK_ARD,               16'h0,    16'h0,    E_OVF_POS,     16'h7FFF, 16'h0, 0));
        tbl.push_back(mk("ovw_sat_hi",   1, 0, 0, 0, 16'h0,    1, 0, 32'h0010_0000, 5,  5,  0, CK_ACC,                      16'h0,    16'h0,    32'h0010_0000, 16'h0,    16'h0, 0));
        tbl.push_back(mk("ovw_sat_lo",   1, 0, 0, 0, 16'h0,    1, 0, 32'hFFF0_0000, 5,  5,  0, CK_ACC|CK_ARD,               16'h0,    16'h0,    32'hFFF0_0000, 16'h7FFF, 16'h0, 0));
        tbl.push_back(mk("rd_sat_lo",    1, 0, 0, 0, 16'h0,    0, 0, 32'h0,         5,  5,  0, CK_ACC|CK_ARD,               16'h0,    16'h0,    32'hFFF0_0000, 16'h8000, 16'h0, 0));
        tbl.push_back(mk("rd_sh31",      1, 0, 0, 0, 16'h0,    0, 0, 32'h0,         5,  5, 31, CK_ARD,                      16'h0,    16'h0,    32'h0,         16'hFFFF, 16'h0, 0));
        tbl.push_back(mk("ovw_12345",    1, 0, 0, 0, 16'h0,    1, 0, 32'h0001_2345, 5,  5,  8, CK_ACC|CK_ARD,               16'h0,    16'h0,    32'h0001_2345, 16'hF000, 16'h0, 0));
        tbl.push_back(mk("rd_sh8",       1, 0, 0, 0, 16'h0,    0, 0, 32'h0,         5,  5,  8, CK_ARD,                      16'h0,    16'h0,    32'h0,         16'h0123, 16'h0, 0));
        tbl.push_back(mk("wr_ch1",       1, 0, 1, 1, 16'h0AAA, 0, 0, 32'h0,         1,  0,  8, CK_RA|CK_RB|CK_ARD|CK_SV,    16'h0AAA, 16'h0000, 32'h0,         16'h0123, 16'h0, 0));
        tbl.push_back(mk("tick_wr_same", 1, 1, 1, 1, 16'h0BBB, 0, 0, 32'h0,         1,  1,  8, CK_ALL,                      16'h0BBB, 16'h0BBB, 32'h0001_2345, 16'h0123, 16'h0AAA, 1));
        tbl.push_back(mk("after_tick",   1, 0, 0, 0, 16'h0,    0, 0, 32'h0,         1,  1,  8, CK_ALL,                      16'h0BBB, 16'h0BBB, 32'h0001_2345, 16'h0123, 16'h0AAA, 0));
        tbl.push_back(mk("en0_writes",   0, 0, 1, 1, 16'hDEAD, 1, 0, 32'hCAFE_BABE, 1,  1,  8, CK_ALL,                      16'h0BBB, 16'h0BBB, 32'h0001_2345, 16'h0123, 16'h0AAA, 0));
        tbl.push_back(mk("en0_tick",     0, 1, 1, 1, 16'hDEAD, 1, 1, 32'h1,         1,  1,  8, CK_ALL,                      16'h0BBB, 16'h0BBB, 32'h0001_2345, 16'h0123, 16'h0BBB, 1));
        tbl.push_back(mk("both_writes",  1, 0, 1, 2, 16'h8001, 1, 1, 32'hFFFF_FFFF, 2,  1,  8, CK_ALL,                      16'h8001, 16'h0BBB, 32'h0001_2344, 16'h0123, 16'h0BBB, 0));
        tbl.push_back(mk("ovw_neg",      1, 0, 0, 0, 16'h0,    1, 0, 32'h8000_0010, 2,  1,  8, CK_ACC|CK_ARD,               16'h0,    16'h0,    32'h8000_0010, 16'h0123, 16'h0, 0));
        tbl.push_back(mk("add_ovf_neg",  1, 0, 0, 0, 16'h0,    1, 1, 32'hFFFF_FFE0, 2,  1,  8, CK_ACC|CK_ARD,               16'h0,    16'h0,    E_OVF_NEG,     16'h8000, 16'h0, 0));
        tbl.push_back(mk("add_no_we",    1, 0, 0, 0, 16'h0,    0, 1, 32'h1,         2,  1,  8, CK_ACC,                      16'h0,    16'h0,    E_OVF_NEG,     16'h0,    16'h0, 0));

        // Reset state
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) run_vec(tbl[i]);

        // Reset asserted between edges clears outputs without waiting for a clock
        @(negedge clk);
        channel_write_enable = 1'b1; channel_write_addr = 4'd3; channel_write_val = 16'h7777;
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        run_vec(mk("post_rst_rd", 1, 0, 0, 0, 16'h0, 0, 0, 32'h0, 2, 1, 0,
                   CK_ALL, 16'h0, 16'h0, 32'h0, 16'h0, 16'h0, 0));

        // Back-to-back accumulates chain on the just-updated value
        acc_exp = 32'h0;
        run_vec(mk("chain_clr", 1, 0, 0, 0, 16'h0, 1, 0, 32'h0, 0, 0, 0,
                   CK_ACC, 16'h0, 16'h0, acc_exp, 16'h0, 16'h0, 0));
        for (int k = 1; k <= 8; k++) begin
            acc_exp = acc_exp + 32'(k) * 32'h0101_0101;
            v = mk($sformatf("chain_add%0d", k), 1, 0, 0, 0, 16'h0, 1, 1, 32'(k) * 32'h0101_0101,
                   0, 0, 0, CK_ACC, 16'h0, 16'h0, acc_exp, 16'h0, 16'h0, 0);
            run_vec(v);
        end

        // Channel sweep against a bench-side register model
        for (int i = 0; i < 16; i++) mdl[i] = 16'h0;
        for (int i = 0; i < 16; i++) begin
            wv   = 16'(i * 16'h1111) ^ 16'h5A5A;
            ra_i = 4'((i + 15) % 16);
            v = mk($sformatf("sweep_wr%0d", i), 1, 0, 1, 4'(i), wv, 0, 0, 32'h0, ra_i, 4'(i), 0,
                   CK_RA | CK_RB, mdl[ra_i], wv, 32'h0, 16'h0, 16'h0, 0);
            run_vec(v);
            mdl[i] = wv;
        end
        for (int i = 0; i < 16; i++) begin
            v = mk($sformatf("sweep_rd%0d", i), 1, 0, 0, 0, 16'h0, 0, 0, 32'h0, 4'(i), 4'(15 - i), 0,
                   CK_RA | CK_RB, mdl[i], mdl[15 - i], 32'h0, 16'h0, 16'h0, 0);
            run_vec(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
